// File: rtl/wb_master_pkg.sv
// Shared Wishbone bus payloads and the initiator state encoding.
package wb_master_pkg;

    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FLUSH_W = 5;
    localparam int unsigned WEQ_D   = 16;

    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } m2s_s;

    typedef struct packed {
        logic              ack;
        logic              err;
        logic              stall;
        logic [DATA_W-1:0] data;
    } s2m_s;

    typedef enum logic [1:0] {WBM_IDLE, WBM_BUSY, WBM_ABORT} wbm_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Counts consecutive armed cycles without a kick; flags expiry on the TIMEOUT-th such cycle.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    // Expiry is seen in the same cycle the last quiet cycle elapses so an err can coincide.
    assign expired = arm && !kick && (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!arm || kick || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/wb_master.sv
// Pipelined Wishbone initiator: valid/ready request stream in, in-order responses out,
// bus recovery on slave error or watchdog timeout.
module wb_master
    import wb_master_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_data,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              timeout,
    output m2s_s              m2s,
    input  s2m_s              s2m
);

    wbm_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic [WEQ_D-1:0]    weq_q, weq_d;
    m2s_s                m2s_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;
    logic                timeout_d;

    logic                issue;
    logic                resp_ev;
    logic                accept;
    logic                expired;
    logic [CNT_W-1:0]    widx;

    assign req_ready = (state_q != WBM_ABORT)
                    && (!m2s.stb || !s2m.stall)
                    && ((FLUSH_W'(count_q) + FLUSH_W'(m2s.stb)) < FLUSH_W'(MAX_OUTSTANDING));

    assign accept  = req_valid && req_ready;
    assign issue   = m2s.stb && !s2m.stall;
    assign resp_ev = (state_q == WBM_BUSY) && m2s.cyc && (count_q != '0) && (s2m.ack || s2m.err);
    // Issued transfer lands behind the entries still in flight after this cycle's pop.
    assign widx    = count_q - CNT_W'(resp_ev);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     ((state_q == WBM_BUSY) && (count_q != '0)),
        .kick    (s2m.ack || s2m.err),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WBM_IDLE;
            count_q   <= '0;
            flush_q   <= '0;
            weq_q     <= '0;
            m2s       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            weq_q     <= weq_d;
            m2s       <= m2s_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        flush_d     = flush_q;
        weq_d       = weq_q;
        m2s_d       = m2s;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            WBM_IDLE, WBM_BUSY: begin
                if (accept) begin
                    m2s_d.stb  = 1'b1;
                    m2s_d.addr = req_addr;
                    m2s_d.data = req_data;
                    m2s_d.we   = req_we;
                    m2s_d.sel  = req_sel;
                end else if (issue) begin
                    m2s_d.stb = 1'b0;
                end

                count_d   = count_q + CNT_W'(issue) - CNT_W'(resp_ev);
                m2s_d.cyc = m2s_d.stb || (count_d != '0);

                // Write-enable history of in-flight transfers, oldest at bit 0.
                weq_d = resp_ev ? (weq_q >> 1) : weq_q;
                if (issue) begin
                    weq_d[widx] = m2s.we;
                end

                if (resp_ev) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = s2m.err;
                    rsp_data_d  = (!s2m.err && !weq_q[0]) ? s2m.data : '0;
                end

                if ((state_q == WBM_BUSY) && ((resp_ev && s2m.err) || expired)) begin
                    state_d   = WBM_ABORT;
                    flush_d   = FLUSH_W'(count_d) + FLUSH_W'(m2s_d.stb);
                    count_d   = '0;
                    weq_d     = '0;
                    m2s_d     = '0;
                    timeout_d = expired;
                end else if (m2s_d.cyc) begin
                    state_d = WBM_BUSY;
                end else begin
                    state_d = WBM_IDLE;
                end
            end

            WBM_ABORT: begin
                // One error response per abandoned transfer; bus ack/err are ignored here.
                if (flush_q != '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    flush_d     = flush_q - FLUSH_W'(1);
                end
                if (flush_q <= FLUSH_W'(1)) begin
                    state_d = WBM_IDLE;
                end
            end

            default: begin
                state_d = WBM_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master with hand-computed expectations per cycle.
module tb_wb_master;
    import wb_master_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_data;
    logic [SEL_W-1:0]  req_sel;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              timeout;
    m2s_s              m2s;
    s2m_s              s2m;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_master #(
        .MAX_OUTSTANDING (4),
        .TIMEOUT         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .timeout   (timeout),
        .m2s       (m2s),
        .s2m       (s2m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [ADDR_W-1:0] a, input logic we,
                           input logic [DATA_W-1:0] d);
        req_valid = v;
        req_addr  = a;
        req_we    = we;
        req_data  = d;
        req_sel   = 4'hF;
    endtask

    task automatic set_s2m(input logic ack, input logic err, input logic stall,
                           input logic [DATA_W-1:0] d);
        s2m.ack   = ack;
        s2m.err   = err;
        s2m.stall = stall;
        s2m.data  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed run still active expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);
        set_s2m(1'b0, 1'b0, 1'b0, '0);

        // Reset state
        tick();
        tick();
        check("rst_cyc_stb_we", 32'({m2s.cyc, m2s.stb, m2s.we}), 32'd0);
        check("rst_addr", 32'(m2s.addr), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, timeout}), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_count", 32'(dut.count_q), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(WBM_IDLE));
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);

        // Single read, ack two cycles after issue
        set_req(1'b1, 30'h100, 1'b0, '0);
        #1 check("t1_ready", 32'(req_ready), 32'd1);
        tick();
        check("t1_cyc_stb", 32'({m2s.cyc, m2s.stb}), 32'b11);
        check("t1_addr", 32'(m2s.addr), 32'h100);
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t1_issued", 32'({m2s.cyc, m2s.stb}), 32'b10);
        check("t1_count", 32'(dut.count_q), 32'd1);
        tick();
        check("t1_wait", 32'({m2s.cyc, rsp_valid}), 32'b10);
        set_s2m(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        tick();
        check("t1_rsp", 32'({rsp_valid, rsp_err, m2s.cyc}), 32'b100);
        check("t1_rsp_data", rsp_data, 32'hDEADBEEF);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        tick();
        check("t1_rsp_done", 32'(rsp_valid), 32'd0);
        check("t1_state", 32'(dut.state_q), 32'(WBM_IDLE));

        // Back-to-back writes up to the outstanding limit
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 30'h200 + 30'(i), 1'b1, 32'h1000 + 32'(i));
            #1 check($sformatf("t2_ready%0d", i), 32'(req_ready), 32'd1);
            tick();
            check($sformatf("t2_addr%0d", i), 32'(m2s.addr), 32'h200 + 32'(i));
            check($sformatf("t2_data%0d", i), m2s.data, 32'h1000 + 32'(i));
            check($sformatf("t2_we%0d", i), 32'({m2s.stb, m2s.we}), 32'b11);
        end
        set_req(1'b1, 30'h204, 1'b1, 32'h1004);
        #1 check("t2_full_ready", 32'(req_ready), 32'd0);
        tick();
        check("t2_peak_count", 32'(dut.count_q), 32'd4);
        check("t2_peak_bus", 32'({m2s.cyc, m2s.stb, req_ready}), 32'b100);
        set_s2m(1'b1, 1'b0, 1'b0, 32'h99999999);
        tick();
        check("t2_ack1", 32'({rsp_valid, rsp_err, req_ready}), 32'b101);
        check("t2_ack1_data", rsp_data, 32'd0);
        check("t2_ack1_count", 32'(dut.count_q), 32'd3);
        tick();
        check("t2_fifth_addr", 32'(m2s.addr), 32'h204);
        check("t2_fifth_stb", 32'({m2s.stb, rsp_valid}), 32'b11);
        check("t2_count_e7", 32'(dut.count_q), 32'd2);
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t2_count_e8", 32'(dut.count_q), 32'd2);
        tick();
        check("t2_count_e9", 32'(dut.count_q), 32'd1);
        tick();
        check("t2_last", 32'({rsp_valid, m2s.cyc}), 32'b10);
        check("t2_count_end", 32'(dut.count_q), 32'd0);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        tick();
        check("t2_quiet", 32'(rsp_valid), 32'd0);

        // Stall holds the second request on the bus
        set_req(1'b1, 30'h300, 1'b0, '0);
        tick();
        set_req(1'b1, 30'h301, 1'b0, '0);
        tick();
        check("t3_addr_r1", 32'(m2s.addr), 32'h301);
        check("t3_count1", 32'(dut.count_q), 32'd1);
        set_req(1'b1, 30'h302, 1'b0, '0);
        set_s2m(1'b0, 1'b0, 1'b1, '0);
        #1 check("t3_stall_ready", 32'(req_ready), 32'd0);
        tick();
        check("t3_hold1", 32'({m2s.stb, req_ready}), 32'b10);
        check("t3_hold1_addr", 32'(m2s.addr), 32'h301);
        set_s2m(1'b1, 1'b0, 1'b1, 32'hA0A0A0A0);
        tick();
        check("t3_r0_rsp", 32'({rsp_valid, rsp_err, m2s.cyc}), 32'b101);
        check("t3_r0_data", rsp_data, 32'hA0A0A0A0);
        check("t3_hold2_addr", 32'(m2s.addr), 32'h301);
        set_s2m(1'b0, 1'b0, 1'b1, '0);
        tick();
        check("t3_hold3", 32'({m2s.stb, rsp_valid}), 32'b10);
        check("t3_hold3_addr", 32'(m2s.addr), 32'h301);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        #1 check("t3_unstall_ready", 32'(req_ready), 32'd1);
        tick();
        check("t3_addr_r2", 32'(m2s.addr), 32'h302);
        check("t3_count_e6", 32'(dut.count_q), 32'd1);
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t3_count_e7", 32'(dut.count_q), 32'd2);
        set_s2m(1'b1, 1'b0, 1'b0, 32'hB1B1B1B1);
        tick();
        check("t3_r1_data", rsp_data, 32'hB1B1B1B1);
        check("t3_r1_valid", 32'({rsp_valid, rsp_err}), 32'b10);
        set_s2m(1'b1, 1'b0, 1'b0, 32'hC2C2C2C2);
        tick();
        check("t3_r2_data", rsp_data, 32'hC2C2C2C2);
        check("t3_r2_cyc", 32'({rsp_valid, m2s.cyc}), 32'b10);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        tick();

        // Slave error on the oldest of three in flight
        set_req(1'b1, 30'h400, 1'b0, '0);
        tick();
        set_req(1'b1, 30'h401, 1'b0, '0);
        tick();
        set_req(1'b1, 30'h402, 1'b0, '0);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t4_count3", 32'(dut.count_q), 32'd3);
        set_s2m(1'b0, 1'b1, 1'b0, 32'h55555555);
        tick();
        check("t4_err_rsp", 32'({rsp_valid, rsp_err, m2s.cyc, m2s.stb}), 32'b1100);
        check("t4_err_data", rsp_data, 32'd0);
        check("t4_state_abort", 32'(dut.state_q), 32'(WBM_ABORT));
        set_s2m(1'b1, 1'b0, 1'b0, 32'h77777777);
        set_req(1'b1, 30'h4FF, 1'b0, '0);
        #1 check("t4_abort_ready", 32'(req_ready), 32'd0);
        tick();
        check("t4_flush1", 32'({rsp_valid, rsp_err, m2s.cyc}), 32'b110);
        check("t4_flush1_data", rsp_data, 32'd0);
        check("t4_flush1_ready", 32'(req_ready), 32'd0);
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t4_flush2", 32'({rsp_valid, rsp_err, m2s.cyc}), 32'b110);
        check("t4_state_idle", 32'(dut.state_q), 32'(WBM_IDLE));
        tick();
        check("t4_late_ack", 32'({rsp_valid, m2s.cyc}), 32'b00);
        check("t4_count0", 32'(dut.count_q), 32'd0);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        tick();

        // Watchdog expiry with two writes unanswered
        set_req(1'b1, 30'h500, 1'b1, 32'hAAAA0000);
        tick();
        set_req(1'b1, 30'h501, 1'b1, 32'hAAAA0001);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t5_count2", 32'(dut.count_q), 32'd2);
        repeat (6) tick();
        check("t5_pre_timeout", 32'({timeout, m2s.cyc, rsp_valid}), 32'b010);
        tick();
        check("t5_timeout", 32'({timeout, m2s.cyc, rsp_valid}), 32'b100);
        check("t5_state_abort", 32'(dut.state_q), 32'(WBM_ABORT));
        tick();
        check("t5_flush1", 32'({timeout, rsp_valid, rsp_err}), 32'b011);
        tick();
        check("t5_flush2", 32'({rsp_valid, rsp_err}), 32'b11);
        check("t5_idle_ready", 32'(req_ready), 32'd1);
        check("t5_state_idle", 32'(dut.state_q), 32'(WBM_IDLE));
        tick();
        check("t5_quiet", 32'(rsp_valid), 32'd0);

        // Stray ack while idle, then reset in the middle of a burst
        set_s2m(1'b1, 1'b0, 1'b0, 32'h12345678);
        tick();
        check("t6_stray_ack", 32'({rsp_valid, m2s.cyc}), 32'b00);
        check("t6_stray_count", 32'(dut.count_q), 32'd0);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        set_req(1'b1, 30'h600, 1'b0, '0);
        tick();
        set_req(1'b1, 30'h601, 1'b0, '0);
        tick();
        set_req(1'b0, '0, 1'b0, '0);
        tick();
        check("t6_count2", 32'(dut.count_q), 32'd2);
        set_s2m(1'b1, 1'b0, 1'b0, 32'h600D600D);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_bus", 32'({m2s.cyc, m2s.stb, m2s.we}), 32'd0);
        check("t6_rst_addr", 32'(m2s.addr), 32'd0);
        check("t6_rst_rsp", 32'({rsp_valid, rsp_err, timeout}), 32'd0);
        check("t6_rst_count", 32'(dut.count_q), 32'd0);
        check("t6_rst_state", 32'(dut.state_q), 32'(WBM_IDLE));
        tick();
        check("t6_in_rst_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t6_post_rst", 32'({rsp_valid, m2s.cyc}), 32'b00);
        set_s2m(1'b0, 1'b0, 1'b0, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
